// File: rtl/prince_cms_pkg.sv
// Shared constants and types for the first-order CMS PRINCE inverse S-box.
// Holds the share geometry, the per-output-bit algebraic normal form of
// S^-1 used by the share-expansion logic, and the plain S^-1 reference table.
package prince_cms_pkg;

  localparam int NSHARE      = 2;
  localparam int NEXP        = 8;
  localparam int RND_W       = 28;
  localparam int RND_PER_BIT = 7;

  typedef logic [NSHARE*4-1:0] share_vec_t;
  typedef logic [NEXP-1:0]     exp_vec_t;

  // ANF coefficient masks of S^-1, one per output bit; bit m set means the
  // monomial prod(x[v] for v in m) is present. All monomials are degree <= 3.
  //   y0 = 1 ^ x0x1 ^ x1x2 ^ x3 ^ x0x1x3 ^ x2x3 ^ x0x2x3
  //   y1 = 1 ^ x0x2 ^ x1x2 ^ x0x1x2 ^ x1x3 ^ x2x3
  //   y2 = x0 ^ x0x1 ^ x2 ^ x0x2 ^ x1x2 ^ x0x1x2 ^ x1x3 ^ x0x1x3
  //   y3 = 1 ^ x0 ^ x1 ^ x0x1 ^ x0x2 ^ x1x2 ^ x0x1x2 ^ x2x3 ^ x0x2x3 ^ x1x2x3
  localparam logic [15:0] SINV_ANF [4] = '{16'h3949, 16'h14E1, 16'h0CFA, 16'h70EF};

  // Unmasked S^-1 lookup, index 0..F.
  localparam logic [3:0] SINV_TABLE [16] = '{
    4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
    4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1
  };

endpackage

// File: rtl/prince_sinv_cms_bit.sv
// Share expansion for one output bit of the CMS PRINCE inverse S-box.
// Component e (0..7) takes share e[0] of x0, e[1] of x1, e[2] of x2 and
// e[0]^e[1]^e[2] of x3. Any three variables then see every share combination
// exactly once across the eight components, so each cubic monomial is
// covered exactly once. Lower-degree monomials are placed only in the
// components where enough unused variables sit on share 0, which again
// selects each share combination exactly once. No component ever touches
// both shares of one variable.
module prince_sinv_cms_bit
  import prince_cms_pkg::*;
#(
  parameter logic [15:0] COEF = 16'h0000
) (
  input  share_vec_t x_sh,
  output exp_vec_t   comp
);

  function automatic int share_of(input int v, input int e);
    if (v < 3) return (e >> v) & 1;
    return (e ^ (e >> 1) ^ (e >> 2)) & 1;
  endfunction

  // Build each component as the XOR of its assigned monomial share-products.
  always_comb begin
    logic term;
    logic incl;
    int   need;
    comp = '0;
    term = 1'b0;
    incl = 1'b0;
    need = 0;
    for (int e = 0; e < NEXP; e++) begin
      for (int m = 0; m < 16; m++) begin
        if (COEF[m]) begin
          term = 1'b1;
          incl = 1'b1;
          need = 3 - $countones(m[3:0]);
          for (int v = 0; v < 4; v++) begin
            if (m[v]) begin
              term = term & x_sh[4*share_of(v, e) + v];
            end else if (need > 0) begin
              incl = incl & (share_of(v, e) == 0);
              need--;
            end
          end
          if (incl) comp[e] = comp[e] ^ term;
        end
      end
    end
  end

endmodule

// File: rtl/prince_sbox_inv_cms.sv
// First-order CMS PRINCE inverse S-box with a valid/ready interface.
// Stage 1 registers the eight expanded shares per output bit together with
// the fresh randomness; the compression back to two shares is combinational
// from that register. Defining PRINCE_SBOX_INV_CMS_OUTREG_EN adds a second
// register on the compressed shares (latency 2 instead of 1).
// Only NSHARE=2 and NEXP=8 are supported.
module prince_sbox_inv_cms
  import prince_cms_pkg::RND_W, prince_cms_pkg::SINV_ANF;
#(
  parameter int NSHARE = 2,
  parameter int NEXP   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [NSHARE*4-1:0]   x_sh_i,
  input  logic [RND_W-1:0]      rnd_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [NSHARE*4-1:0]   y_sh_o
);

  logic [3:0][NEXP-1:0] comp_d;
  logic [3:0][NEXP-1:0] exp_q;
  logic [RND_W-1:0]     rnd_q;
  logic                 full1;
  logic                 s1_take;
  logic                 s1_release;
  logic [NSHARE*4-1:0]  y_d;

  for (genvar b = 0; b < 4; b++) begin : g_bit
    prince_sinv_cms_bit #(.COEF(SINV_ANF[b])) u_bit (
      .x_sh (x_sh_i),
      .comp (comp_d[b])
    );
  end

  assign s1_take = in_valid_i && in_ready_o;

  // Stage-1 register: expanded shares and their refresh randomness move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full1 <= 1'b0;
      exp_q <= '0;
      rnd_q <= '0;
    end else if (s1_take) begin
      full1 <= 1'b1;
      exp_q <= comp_d;
      rnd_q <= rnd_i;
    end else if (s1_release) begin
      full1 <= 1'b0;
    end
  end

  // Ring refresh: share k picks up mask bits k and k-1, so each mask bit
  // enters exactly two shares and cancels in the sum; then 4+4 compression.
  always_comb begin
    logic [6:0]      m;
    logic [NEXP-1:0] q;
    y_d = '0;
    m   = '0;
    q   = '0;
    for (int b = 0; b < 4; b++) begin
      m = rnd_q[7*b +: 7];
      q = exp_q[b] ^ {1'b0, m} ^ {m, 1'b0};
      y_d[b]     = ^q[3:0];
      y_d[4 + b] = ^q[7:4];
    end
  end

`ifdef PRINCE_SBOX_INV_CMS_OUTREG_EN
  logic                full2;
  logic                s2_ready;
  logic [NSHARE*4-1:0] y_q;

  assign s2_ready    = !full2 || out_ready_i;
  assign s1_release  = s2_ready;
  assign in_ready_o  = !full1 || s2_ready;
  assign out_valid_o = full2;
  assign y_sh_o      = y_q;

  // Stage-2 register on the compressed shares; refills while draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full2 <= 1'b0;
      y_q   <= '0;
    end else if (full1 && s2_ready) begin
      full2 <= 1'b1;
      y_q   <= y_d;
    end else if (out_ready_i) begin
      full2 <= 1'b0;
    end
  end
`else
  assign s1_release  = out_ready_i;
  assign in_ready_o  = !full1 || out_ready_i;
  assign out_valid_o = full1;
  assign y_sh_o      = y_d;
`endif

endmodule
